// File: rtl/dcache_ctrl_if.sv
// Bus bundle between the controller/backing memory side and the data cache.
// The cache takes the slave view; whoever drives requests and acks takes the master view.
interface dcache_ctrl_if #(
    parameter int NBITS = 8,
    parameter int NCNT  = 8
);
    logic [NBITS-1:0] addr;
    logic [NBITS-1:0] wdata;
    logic             MemRead;
    logic             MemWrite;
    logic [NBITS-1:0] rdata;
    logic             busy;
    logic             mem_req;
    logic             mem_we;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic             mem_ack;
    logic [NBITS-1:0] mem_rdata;
    logic [NCNT-1:0]  hit_count;
    logic [NCNT-1:0]  miss_count;

    modport master (
        output addr, wdata, MemRead, MemWrite, mem_ack, mem_rdata,
        input  rdata, busy, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );

    modport slave (
        input  addr, wdata, MemRead, MemWrite, mem_ack, mem_rdata,
        output rdata, busy, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a slow
// req/ack backing memory; hits are stall-free, misses and stores stall via busy.
module dcache_ctrl #(
    parameter int NBITS  = 8,
    parameter int NLINES = 8,
    parameter int NCNT   = 8
) (
    input logic          clock,
    input logic          reset,
    dcache_ctrl_if.slave bus
);
    localparam int IW = $clog2(NLINES);
    localparam int TW = NBITS - IW;
    localparam logic [NCNT-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, MISS, WRITE, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [NLINES-1:0] valid;
    logic [TW-1:0]     tags [NLINES];
    logic [NBITS-1:0]  data [NLINES];

    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic [IW-1:0] fill_index;
    logic [TW-1:0] fill_tag;
    logic          hit;

    logic store_start;
    logic load_hit;
    logic load_miss;
    logic fill;
    logic write_done;

    assign index      = bus.addr[IW-1:0];
    assign tag        = bus.addr[NBITS-1:IW];
    assign fill_index = bus.mem_addr[IW-1:0];
    assign fill_tag   = bus.mem_addr[NBITS-1:IW];
    assign hit        = valid[index] && (tags[index] == tag);

    assign store_start = (state == IDLE) && bus.MemWrite;
    assign load_hit    = (state == IDLE) && !bus.MemWrite && bus.MemRead && hit;
    assign load_miss   = (state == IDLE) && !bus.MemWrite && bus.MemRead && !hit;
    assign fill        = (state == MISS) && bus.mem_ack;
    assign write_done  = (state == WRITE) && bus.mem_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (store_start) begin
                    state_next = WRITE;
                end else if (load_miss) begin
                    state_next = MISS;
                end
            end
            MISS:    if (bus.mem_ack) state_next = DONE;
            WRITE:   if (bus.mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // DONE hands back whatever the array now holds for addr, i.e. the freshly filled byte.
    always_comb begin
        bus.busy  = 1'b0;
        bus.rdata = '0;
        case (state)
            IDLE: begin
                bus.busy = store_start || load_miss;
                if (load_hit) begin
                    bus.rdata = data[index];
                end
            end
            MISS, WRITE: bus.busy = 1'b1;
            DONE:        bus.rdata = data[index];
            default:     bus.busy = 1'b0;
        endcase
    end

    // mem_addr/mem_wdata double as the latched request for the rest of the transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid          <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.hit_count  <= '0;
            bus.miss_count <= '0;
        end else begin
            if (store_start) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= bus.addr;
                bus.mem_wdata <= bus.wdata;
            end else if (load_miss) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= bus.addr;
            end else if (fill || write_done) begin
                bus.mem_req <= 1'b0;
            end
            if (fill) begin
                valid[fill_index] <= 1'b1;
            end
            if (load_hit && bus.hit_count != CNT_MAX) begin
                bus.hit_count <= bus.hit_count + NCNT'(1);
            end
            if (load_miss && bus.miss_count != CNT_MAX) begin
                bus.miss_count <= bus.miss_count + NCNT'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (store_start && hit) begin
                data[index] <= bus.wdata;
            end
            if (fill) begin
                tags[fill_index] <= fill_tag;
                data[fill_index] <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later, well clear of the rising edge.
module tb_dcache_ctrl;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    dcache_ctrl_if #(.NBITS(8), .NCNT(8)) bus ();

    dcache_ctrl #(.NBITS(8), .NLINES(8), .NCNT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        @(negedge clock);
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.addr     = a;
        bus.wdata    = wd;
        #1;
    endtask

    // Waits the given number of cycles, then pulses mem_ack for one cycle; ends in the DONE cycle.
    task automatic serve(input int delay, input logic [7:0] rd);
        repeat (delay) @(negedge clock);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        #1;
    endtask

    task automatic idle();
        @(negedge clock);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_mem_wdata: got %h want 00", bus.mem_wdata); end
        checks++; if (bus.hit_count !== 8'd0 || bus.miss_count !== 8'd0) begin failures++; $display("FAIL reset_counts: got hit=%0d miss=%0d want 0/0", bus.hit_count, bus.miss_count); end
        checks++; if (bus.busy !== 1'b0 || bus.rdata !== 8'h00) begin failures++; $display("FAIL reset_idle_out: got busy=%0b rdata=%h want 0/00", bus.busy, bus.rdata); end
    endtask

    task automatic test_load_miss();
        issue(1'b1, 1'b0, 8'h13, 8'h00);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL miss_busy_same_cycle: got %0b want 1", bus.busy); end
        @(negedge clock); #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h13) begin
            failures++; $display("FAIL miss_mem_req: got req=%0b we=%0b addr=%h want 1/0/13", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        checks++; if (bus.miss_count !== 8'd1) begin failures++; $display("FAIL miss_count_1: got %0d want 1", bus.miss_count); end
        repeat (2) @(negedge clock);
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("FAIL miss_hold: got req=%0b busy=%0b want 1/1", bus.mem_req, bus.busy); end
        serve(0, 8'h5A);
        checks++; if (bus.busy !== 1'b0 || bus.rdata !== 8'h5A) begin failures++; $display("FAIL miss_done: got busy=%0b rdata=%h want 0/5a", bus.busy, bus.rdata); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL miss_req_drop: got %0b want 0", bus.mem_req); end
        idle();
        checks++; if (bus.busy !== 1'b0 || bus.rdata !== 8'h00) begin failures++; $display("FAIL after_done_idle: got busy=%0b rdata=%h want 0/00", bus.busy, bus.rdata); end
    endtask

    task automatic test_load_hit();
        issue(1'b1, 1'b0, 8'h13, 8'h00);
        checks++; if (bus.busy !== 1'b0 || bus.rdata !== 8'h5A) begin failures++; $display("FAIL hit_data: got busy=%0b rdata=%h want 0/5a", bus.busy, bus.rdata); end
        idle();
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL hit_no_req: got %0b want 0", bus.mem_req); end
        checks++; if (bus.hit_count !== 8'd1 || bus.miss_count !== 8'd1) begin failures++; $display("FAIL hit_counts: got hit=%0d miss=%0d want 1/1", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_store_hit();
        issue(1'b0, 1'b1, 8'h13, 8'hC3);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL store_busy: got %0b want 1", bus.busy); end
        @(negedge clock); #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h13 || bus.mem_wdata !== 8'hC3) begin
            failures++; $display("FAIL store_mem: got req=%0b we=%0b addr=%h wdata=%h want 1/1/13/c3", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        serve(1, 8'h00);
        checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL store_done: got busy=%0b req=%0b want 0/0", bus.busy, bus.mem_req); end
        idle();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL store_one_done: got busy=%0b want 0", bus.busy); end
        issue(1'b1, 1'b0, 8'h13, 8'h00);
        checks++; if (bus.busy !== 1'b0 || bus.rdata !== 8'hC3 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL store_then_hit: got busy=%0b rdata=%h req=%0b want 0/c3/0", bus.busy, bus.rdata, bus.mem_req);
        end
        idle();
        checks++; if (bus.hit_count !== 8'd2 || bus.miss_count !== 8'd1) begin failures++; $display("FAIL store_counts: got hit=%0d miss=%0d want 2/1", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_conflict_no_allocate();
        issue(1'b1, 1'b0, 8'h1B, 8'h00);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL conflict_miss_1b: got busy=%0b want 1", bus.busy); end
        serve(2, 8'h77);
        checks++; if (bus.rdata !== 8'h77) begin failures++; $display("FAIL conflict_fill_1b: got %h want 77", bus.rdata); end
        idle();
        issue(1'b1, 1'b0, 8'h13, 8'h00);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL conflict_evicted_13: got busy=%0b want 1", bus.busy); end
        serve(1, 8'hC3);
        idle();
        issue(1'b0, 1'b1, 8'h40, 8'h11);
        @(negedge clock); #1;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h40 || bus.mem_wdata !== 8'h11) begin
            failures++; $display("FAIL store_miss_mem: got we=%0b addr=%h wdata=%h want 1/40/11", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        serve(0, 8'h00);
        idle();
        issue(1'b1, 1'b0, 8'h40, 8'h00);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL no_allocate_40: got busy=%0b want 1", bus.busy); end
        serve(1, 8'h11);
        checks++; if (bus.rdata !== 8'h11) begin failures++; $display("FAIL fill_40: got %h want 11", bus.rdata); end
        idle();
        checks++; if (bus.miss_count !== 8'd4 || bus.hit_count !== 8'd2) begin failures++; $display("FAIL conflict_counts: got hit=%0d miss=%0d want 2/4", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_read_write_priority();
        issue(1'b1, 1'b1, 8'h05, 8'h9E);
        @(negedge clock); #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h9E) begin
            failures++; $display("FAIL priority_store: got req=%0b we=%0b wdata=%h want 1/1/9e", bus.mem_req, bus.mem_we, bus.mem_wdata);
        end
        serve(1, 8'h00);
        idle();
        checks++; if (bus.miss_count !== 8'd4) begin failures++; $display("FAIL priority_miss_count: got %0d want 4", bus.miss_count); end
    endtask

    task automatic test_reset_mid_miss();
        issue(1'b1, 1'b0, 8'h2A, 8'h00);
        @(negedge clock);
        reset        = 1'b1;
        bus.MemRead  = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL abort_pre_req: got %0b want 1", bus.mem_req); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_req_drop: got req=%0b busy=%0b want 0/0", bus.mem_req, bus.busy); end
        checks++; if (bus.hit_count !== 8'd0 || bus.miss_count !== 8'd0) begin failures++; $display("FAIL abort_counts: got hit=%0d miss=%0d want 0/0", bus.hit_count, bus.miss_count); end
        serve(0, 8'h99);
        checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL late_ack_ignored: got req=%0b busy=%0b want 0/0", bus.mem_req, bus.busy); end
        issue(1'b1, 1'b0, 8'h13, 8'h00);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL invalidated_13: got busy=%0b want 1", bus.busy); end
        serve(1, 8'hC3);
        checks++; if (bus.rdata !== 8'hC3) begin failures++; $display("FAIL refill_13: got %h want c3", bus.rdata); end
        idle();
        checks++; if (bus.miss_count !== 8'd1) begin failures++; $display("FAIL refill_miss_count: got %0d want 1", bus.miss_count); end
    endtask

    task automatic test_hit_saturation();
        issue(1'b1, 1'b0, 8'h13, 8'h00);
        for (int i = 1; i <= 300; i++) begin
            @(negedge clock); #1;
            if (i == 100) begin
                checks++; if (bus.hit_count !== 8'd100) begin failures++; $display("FAIL hit_count_100: got %0d want 100", bus.hit_count); end
            end
        end
        checks++; if (bus.hit_count !== 8'd255) begin failures++; $display("FAIL hit_saturate: got %0d want 255", bus.hit_count); end
        checks++; if (bus.busy !== 1'b0 || bus.rdata !== 8'hC3) begin failures++; $display("FAIL hit_stream_data: got busy=%0b rdata=%h want 0/c3", bus.busy, bus.rdata); end
        idle();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_conflict_no_allocate();
        test_read_write_priority();
        test_reset_mid_miss();
        test_hit_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Data-memory stage directly downstream of the processor controller.
- Consumes MemRead/MemWrite, the ALU-computed address and the store data. Produces load data and the busy stall signal.
- Small direct-mapped, write-through, no-write-allocate cache in front of a slow backing data memory with a req/ack handshake.
- Hits complete with zero stall. Misses and all stores hold busy until the backing memory acknowledges.

Parameters:
- NBITS, 8, address and data width.
- NLINES, 8, number of cache lines (power of 2, one byte per line); index = addr[$clog2(NLINES)-1:0], tag = remaining upper address bits.
- NCNT, 8, width of the hit/miss performance counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  NBITS  byte address from ALU result
- wdata  in  NBITS  store data
- MemRead  in  1  load request
- MemWrite  in  1  store request
- rdata  out  NBITS  load data
- busy  out  1  stall request to controller
- mem_req  out  1  backing-memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  NBITS  backing-memory address
- mem_wdata  out  NBITS  backing-memory write data
- mem_ack  in  1  backing memory done (one-cycle pulse)
- mem_rdata  in  NBITS  read data, valid when mem_ack=1
- hit_count  out  NCNT  saturating count of load hits
- miss_count  out  NCNT  saturating count of load misses

Behaviour:
- Clock is clock; reset is reset, synchronous, active-high.
- Reset values:
  - state = IDLE.
  - All valid bits 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - hit_count = 0, miss_count = 0.
  - Tag and data arrays are not reset.
- Hit = valid[index] && tag[index] == addr tag.
- States: IDLE, MISS, WRITE, DONE.
- IDLE:
  - MemWrite=1 (takes priority over MemRead):
    - busy=1 combinationally.
    - Latch addr/wdata.
    - If hit, update the line data this edge.
    - Next state is WRITE.
  - MemRead=1, hit:
    - busy=0, rdata=data[index] combinationally.
    - hit_count++ (saturating).
    - Stay in IDLE.
  - MemRead=1, miss:
    - busy=1 combinationally.
    - Latch addr.
    - miss_count++ (saturating).
    - Next state is MISS.
  - Neither request: busy=0, rdata=0.
- MISS:
  - Registered outputs mem_req=1, mem_we=0, mem_addr=latched addr; asserted from the first MISS cycle and held until mem_ack.
  - busy=1.
  - On mem_ack: write valid=1, tag, and data=mem_rdata into the line; mem_req drops on the next edge; next state is DONE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values, held until mem_ack.
  - busy=1.
  - On mem_ack: next state is DONE.
  - Write-through only; a miss does not allocate.
- DONE:
  - busy=0 for exactly one cycle.
  - rdata = array lookup of addr (returns the filled byte for a load).
  - MemRead/MemWrite are ignored; the request has completed.
  - Counters are unchanged.
  - Next state is IDLE.
- Latency:
  - Load hit: 0 stall cycles.
  - Load miss or any store: busy for (backing latency + 1) cycles, then DONE.
- mem_ack outside MISS/WRITE is ignored.
- The controller holds addr/wdata/MemRead/MemWrite stable while busy=1. Behaviour is undefined otherwise.
- Counters saturate at 2^NCNT-1 and never wrap.
- Reset mid-operation:
  - Abort at the reset edge; state goes to IDLE and mem_req is 0 from the next cycle.
  - All lines are invalidated and the counters cleared.
  - A mem_ack arriving after reset is ignored.

Test Plan:
- Reset, then MemRead addr=0x13:
  - Same cycle busy=1.
  - Next cycle mem_req=1, mem_we=0, mem_addr=0x13.
  - Ack 3 cycles later with mem_rdata=0x5A.
  - Next cycle busy=0, rdata=0x5A.
  - miss_count=1.
- MemRead 0x13 again:
  - busy=0, rdata=0x5A same cycle.
  - No mem_req.
  - hit_count=1.
- MemWrite 0x13 wdata=0xC3:
  - busy=1, mem_req=1, mem_we=1, mem_wdata=0xC3.
  - After ack, one DONE cycle.
  - Then MemRead 0x13 hits with rdata=0xC3 and no mem_req.
- Conflict and no-allocate:
  - MemRead 0x1B (index 3, new tag) misses and fills 0x77; a following MemRead 0x13 misses.
  - MemWrite 0x40=0x11 (miss) is followed by MemRead 0x40, which misses; miss_count increments each time.
- Simultaneous MemRead=MemWrite=1 at 0x05: treated as a store (mem_we=1), miss_count unchanged.
- Edge cases:
  - Reset asserted during MISS: mem_req=0 after the reset edge; a late mem_ack is ignored; MemRead 0x13 then misses.
  - 300 consecutive hits leave hit_count=255.
